datapath_seq: RTL and testbench

DATAPATH_SEQ -- requirements
Module: datapath_seq

---
 rtl/datapath_seq.sv | 140 ++++++++++++++
 tb/tb_datapath_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_seq.sv
// Multi-cycle register-file datapath: accepts one operation, loads A, executes, then pulses done.
// Fixed four-state sequence gives constant latency and one operation every four cycles.
module datapath_seq #(
    parameter int W  = 16,
    parameter int NR = 4,
    localparam int RA = $clog2(NR)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          ready,
    input  logic [2:0]    op,
    input  logic [RA-1:0] rd,
    input  logic [RA-1:0] rs,
    input  logic [RA-1:0] ra,
    input  logic [W-1:0]  in,
    output logic [W-1:0]  out,
    output logic          N,
    output logic          Z,
    output logic          done
);

    typedef enum logic [1:0] {S_IDLE, S_LDA, S_EXEC, S_DONE} state_t;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_SHL   = 3'b001;
    localparam logic [2:0] OP_SHL1  = 3'b010;
    localparam logic [2:0] OP_CAT   = 3'b011;
    localparam logic [2:0] OP_SUBH  = 3'b100;
    localparam logic [2:0] OP_ADD   = 3'b101;
    localparam logic [2:0] OP_PASSA = 3'b110;
    localparam logic [2:0] OP_NOP   = 3'b111;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [RA-1:0] rd_q, rd_d;
    logic [RA-1:0] rs_q, rs_d;
    logic [RA-1:0] ra_q, ra_d;
    logic [W-1:0]  in_q, in_d;
    logic [W-1:0]  a_q, a_d;
    logic          n_q, n_d;
    logic          z_q, z_d;
    logic [W-1:0]  regs_q [NR];
    logic [W-1:0]  regs_d [NR];

    logic [W-1:0]  src;
    logic [W-1:0]  result;

    // Source operand is read straight from the file, so rd==rs sees the pre-write value.
    always_comb begin
        src    = regs_q[rs_q];
        result = '0;
        case (op_q)
            OP_LOAD:  result = in_q;
            OP_SHL:   result = {src[W-2:0], 1'b0};
            OP_SHL1:  result = {src[W-2:0], 1'b1};
            OP_CAT:   result = {a_q[W/2-1:0], src[W/2-1:0]};
            OP_SUBH:  result = {{(W/2){1'b0}}, a_q[W-1:W/2]} - src;
            OP_ADD:   result = a_q + src;
            OP_PASSA: result = a_q;
            default:  result = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs_d    = rs_q;
        ra_d    = ra_q;
        in_d    = in_q;
        a_d     = a_q;
        n_d     = n_q;
        z_d     = z_q;
        regs_d  = regs_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LDA;
                    op_d    = op;
                    rd_d    = rd;
                    rs_d    = rs;
                    ra_d    = ra;
                    in_d    = in;
                end
            end
            S_LDA: begin
                a_d     = regs_q[ra_q];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_DONE;
                if (op_q != OP_NOP) begin
                    regs_d[rd_q] = result;
                    n_d          = result[W-1];
                    z_d          = (result == '0);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rs_q    <= '0;
            ra_q    <= '0;
            in_q    <= '0;
            a_q     <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            for (int i = 0; i < NR; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rs_q    <= rs_d;
            ra_q    <= ra_d;
            in_q    <= in_d;
            a_q     <= a_d;
            n_q     <= n_d;
            z_q     <= z_d;
            for (int i = 0; i < NR; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign ready = (state_q == S_IDLE);
    assign done  = (state_q == S_DONE);
    assign out   = regs_q[1];
    assign N     = n_q;
    assign Z     = z_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Bench for datapath_seq: transaction-level model checked every cycle on the W=16 instance,
// plus directed literal checks on both the W=16/NR=4 and W=8/NR=8 instances.
module tb_datapath_seq;

    logic        clk;
    logic        reset;

    logic        start16, rdy16, n16, z16, done16;
    logic [2:0]  op16;
    logic [1:0]  rd16, rs16, ra16;
    logic [15:0] in16, out16;

    logic        start8, rdy8, n8, z8, done8;
    logic [2:0]  op8;
    logic [2:0]  rd8, rs8, ra8;
    logic [7:0]  in8, out8;

    int nvec = 0;
    int nmis = 0;

    datapath_seq #(.W(16), .NR(4)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .ready(rdy16),
        .op(op16), .rd(rd16), .rs(rs16), .ra(ra16), .in(in16),
        .out(out16), .N(n16), .Z(z16), .done(done16)
    );

    datapath_seq #(.W(8), .NR(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .ready(rdy8),
        .op(op8), .rd(rd8), .rs(rs8), .ra(ra8), .in(in8),
        .out(out8), .N(n8), .Z(z8), .done(done8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model of the W=16 instance: an accepted operation reads A one edge
    // later, commits two edges later, and the block is free again three edges later.
    int  m_r [4];
    int  m_a, m_n, m_z;
    bit  m_valid = 1'b0;
    bit  m_busy;
    int  m_age;
    int  p_op, p_rd, p_rs, p_ra, p_in;

    initial begin
        int r;
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int i = 0; i < 4; i++) m_r[i] = 0;
                m_a = 0; m_n = 0; m_z = 0;
                m_busy = 1'b0; m_age = 0; m_valid = 1'b1;
            end else if (m_busy) begin
                m_age++;
                if (m_age == 1) begin
                    m_a = m_r[p_ra];
                end else if (m_age == 2) begin
                    r = 0;
                    case (p_op)
                        0: r = p_in;
                        1: r = (m_r[p_rs] * 2) & 'hFFFF;
                        2: r = ((m_r[p_rs] * 2) + 1) & 'hFFFF;
                        3: r = ((m_a % 256) * 256) + (m_r[p_rs] % 256);
                        4: r = ((m_a / 256) - m_r[p_rs]) & 'hFFFF;
                        5: r = (m_a + m_r[p_rs]) & 'hFFFF;
                        6: r = m_a;
                        default: r = 0;
                    endcase
                    if (p_op != 7) begin
                        m_r[p_rd] = r;
                        m_n = (r >= 'h8000) ? 1 : 0;
                        m_z = (r == 0) ? 1 : 0;
                    end
                end else begin
                    m_busy = 1'b0;
                end
            end else if (start16) begin
                m_busy = 1'b1; m_age = 0;
                p_op = int'(op16); p_rd = int'(rd16); p_rs = int'(rs16);
                p_ra = int'(ra16); p_in = int'(in16);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("ready16", rdy16, !m_busy);
                check("done16", done16, (m_busy && m_age == 2));
                check("out16", out16, m_r[1]);
                check("N16", n16, m_n);
                check("Z16", z16, m_z);
            end
        end
    end

    // Issue one operation; returns the number of falling edges from start to done.
    task automatic do_op(input bit use8, input logic [2:0] o, input int d, input int s,
                         input int a, input logic [15:0] data, input bit noise, output int lat);
        int k;
        k = 0;
        while (!(use8 ? rdy8 : rdy16) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", k < 20, 1);
        if (use8) begin
            start8 = 1'b1; op8 = o; rd8 = d[2:0]; rs8 = s[2:0]; ra8 = a[2:0]; in8 = data[7:0];
        end else begin
            start16 = 1'b1; op16 = o; rd16 = d[1:0]; rs16 = s[1:0]; ra16 = a[1:0]; in16 = data;
        end
        @(negedge clk);
        if (use8) begin
            start8 = 1'b0; op8 = ~o; rd8 = ~rd8; rs8 = ~rs8; ra8 = ~ra8; in8 = ~in8;
        end else begin
            start16 = noise; op16 = noise ? 3'b000 : ~o; in16 = ~data;
            if (!noise) begin
                rd16 = ~rd16; rs16 = ~rs16; ra16 = ~ra16;
            end
        end
        lat = 1;
        while (!(use8 ? done8 : done16) && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        start16 = 1'b0;
    endtask

    initial begin
        int lat;
        reset = 1'b1;
        start16 = 1'b1; op16 = 3'b000; rd16 = 2'd1; rs16 = 2'd0; ra16 = 2'd0; in16 = 16'hFFFF;
        start8  = 1'b1; op8  = 3'b000; rd8  = 3'd1; rs8  = 3'd0; ra8  = 3'd0; in8  = 8'hFF;
        repeat (2) @(negedge clk);
        reset = 1'b0; start16 = 1'b0; start8 = 1'b0;
        check("rst_ready", rdy16, 1);
        check("rst_out", out16, 16'h0000);
        check("rst_nzd", {n16, z16, done16}, 3'b000);
        @(negedge clk);
        check("rst_no_accept", rdy16, 1);

        do_op(0, 3'b000, 1, 0, 0, 16'h8001, 0, lat);
        check("load_latency", lat, 3);
        check("load_out", out16, 16'h8001);
        check("load_nz", {n16, z16}, 2'b10);
        do_op(0, 3'b001, 2, 1, 0, 16'h0, 0, lat);
        check("shl_nz", {n16, z16}, 2'b00);
        do_op(0, 3'b011, 3, 2, 1, 16'h0, 0, lat);
        do_op(0, 3'b110, 1, 0, 3, 16'h0, 0, lat);
        check("cat_r3", out16, 16'h0102);
        do_op(0, 3'b110, 1, 0, 2, 16'h0, 0, lat);
        check("shl_r2", out16, 16'h0002);

        do_op(0, 3'b000, 0, 0, 0, 16'h1234, 0, lat);
        do_op(0, 3'b000, 3, 0, 0, 16'h0013, 0, lat);
        do_op(0, 3'b000, 1, 0, 0, 16'h0001, 0, lat);
        do_op(0, 3'b100, 2, 3, 0, 16'h0, 0, lat);
        check("subh_nz", {n16, z16}, 2'b10);
        do_op(0, 3'b101, 2, 1, 2, 16'h0, 0, lat);
        check("add_nz", {n16, z16}, 2'b01);
        do_op(0, 3'b110, 1, 0, 2, 16'h0, 0, lat);
        check("add_r2", out16, 16'h0000);

        do_op(0, 3'b000, 1, 0, 0, 16'h4000, 0, lat);
        do_op(0, 3'b010, 1, 1, 0, 16'h0, 0, lat);
        check("shl1_out", out16, 16'h8001);
        do_op(0, 3'b101, 1, 1, 1, 16'h0, 0, lat);
        check("add_self", out16, 16'h0002);

        do_op(0, 3'b000, 1, 0, 0, 16'h1111, 1, lat);
        check("noise_latency", lat, 3);
        check("noise_out", out16, 16'h1111);

        @(negedge clk);
        start16 = 1'b1; op16 = 3'b111; rd16 = 2'd1; in16 = 16'h0;
        repeat (9) @(negedge clk);
        start16 = 1'b0;
        repeat (4) @(negedge clk);
        check("hold_out", out16, 16'h1111);

        do_op(0, 3'b000, 1, 0, 0, 16'h8000, 0, lat);
        @(negedge clk);
        start16 = 1'b1; op16 = 3'b000; rd16 = 2'd1; in16 = 16'h7777;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_out", out16, 16'h0000);
        check("abort_state", {rdy16, done16, n16, z16}, 4'b1000);
        repeat (3) begin
            @(negedge clk);
            check("abort_nodone", done16, 0);
        end

        do_op(0, 3'b000, 1, 0, 0, 16'h8000, 0, lat);
        do_op(0, 3'b111, 1, 1, 1, 16'h0000, 0, lat);
        check("nop_latency", lat, 3);
        check("nop_out", out16, 16'h8000);
        check("nop_nz", {n16, z16}, 2'b10);

        do_op(1, 3'b000, 7, 0, 0, 16'h00A5, 0, lat);
        check("w8_load_n", n8, 1);
        do_op(1, 3'b011, 6, 7, 7, 16'h0, 0, lat);
        do_op(1, 3'b110, 1, 0, 6, 16'h0, 0, lat);
        check("w8_cat_r6", out8, 8'h55);
        do_op(1, 3'b110, 0, 0, 7, 16'h0, 0, lat);
        check("w8_passa_nz", {n8, z8}, 2'b10);
        do_op(1, 3'b110, 1, 0, 0, 16'h0, 0, lat);
        check("w8_passa_r0", out8, 8'hA5);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
